pe_inject_arbiter: RTL and testbench

- **Position:** sits between the local processing element (PE) sources of one mesh tile and the PE input port of that tile's switch.
- **Function:**
  - Buffers packets from `N_SRC` independent local requesters in per-source FIFOs.
  - Shares the single switch injection port among them with round-robin arbitration.
  - Presents one registered packet at a time and honours the switch's `o_ready_pe` back-pressure.
  - Keeps injection statistics for performance debug.

---
 rtl/pe_inject_arbiter.sv | 154 +++++++++++++++
 tb/tb_pe_inject_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_inject_arbiter.sv
// Round-robin injection arbiter for one mesh tile. Each local source has its own FIFO.
// A single registered output slot feeds the switch PE port and honours its back-pressure.

module pe_inject_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rd_ptr];
endmodule

module pe_inject_arbiter #(
    parameter int data_width  = 256,
    parameter int x_size      = 1,
    parameter int y_size      = 1,
    parameter int total_width = x_size + y_size + data_width,
    parameter int N_SRC       = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [N_SRC-1:0]              s_valid,
    input  logic [N_SRC*total_width-1:0]  s_data,
    output logic [N_SRC-1:0]              s_ready,
    output logic                          o_valid_pe,
    output logic [total_width-1:0]        o_data_pe,
    input  logic                          i_ready_pe,
    output logic [$clog2(N_SRC)-1:0]      o_grant_src,
    input  logic                          clr_stats,
    output logic [15:0]                   o_stall_cnt,
    output logic [15:0]                   o_pkt_cnt
);
    localparam int GW = $clog2(N_SRC);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [N_SRC-1:0][total_width-1:0] head;
    logic [N_SRC-1:0][CW-1:0]          cnt;
    logic [N_SRC-1:0]                  nonempty, pop;
    logic [GW-1:0]                     last_grant, winner;
    logic                              hit, grant, slot_free, accept, stall;
    state_t                            state, state_nxt;

    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign s_ready[k]  = rstn & (cnt[k] != CW'(FIFO_DEPTH));
        assign nonempty[k] = (cnt[k] != '0);
        pe_inject_fifo #(.W(total_width), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .push  (s_valid[k] & s_ready[k]),
            .din   (s_data[k*total_width +: total_width]),
            .pop   (pop[k]),
            .dout  (head[k]),
            .count (cnt[k])
        );
    end

    assign o_valid_pe = (state == HOLD);
    assign slot_free  = ~o_valid_pe | i_ready_pe;
    assign accept     = o_valid_pe & i_ready_pe;
    assign stall      = o_valid_pe & ~i_ready_pe;

    // Search starts one past the last winner so every non-empty source is served within N_SRC grants.
    always_comb begin
        hit    = 1'b0;
        winner = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (!hit && nonempty[(int'(last_grant) + i) % N_SRC]) begin
                hit    = 1'b1;
                winner = GW'((int'(last_grant) + i) % N_SRC);
            end
        end
    end

    assign grant = slot_free & hit;

    always_comb begin
        pop = '0;
        if (grant) pop[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = HOLD;
            HOLD:    if (i_ready_pe && !hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_data_pe   <= '0;
            o_grant_src <= '0;
            last_grant  <= GW'(N_SRC - 1);
        end else if (grant) begin
            o_data_pe   <= head[winner];
            o_grant_src <= winner;
            last_grant  <= winner;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_pkt_cnt   <= '0;
            o_stall_cnt <= '0;
        end else if (clr_stats) begin
            o_pkt_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (accept) o_pkt_cnt <= o_pkt_cnt + 16'd1;
            if (stall && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pe_inject_arbiter.sv
// Directed bench for pe_inject_arbiter with N_SRC=2, FIFO_DEPTH=4 and a narrow payload.

module tb_pe_inject_arbiter;
    localparam int DW = 8;
    localparam int TW = DW + 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [1:0]    s_valid = '0;
    logic [2*TW-1:0] s_data = '0;
    logic [1:0]    s_ready;
    logic          o_valid_pe;
    logic [TW-1:0] o_data_pe;
    logic          i_ready_pe = 1'b1;
    logic [0:0]    o_grant_src;
    logic          clr_stats = 1'b0;
    logic [15:0]   o_stall_cnt, o_pkt_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_inject_arbiter #(.data_width(DW), .x_size(1), .y_size(1), .N_SRC(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .o_valid_pe(o_valid_pe), .o_data_pe(o_data_pe), .i_ready_pe(i_ready_pe),
        .o_grant_src(o_grant_src), .clr_stats(clr_stats),
        .o_stall_cnt(o_stall_cnt), .o_pkt_cnt(o_pkt_cnt)
    );

    function automatic logic [TW-1:0] mk(input logic [DW-1:0] d, input logic x, input logic y);
        return {d, y, x};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        s_valid = '0;
        #1;
        tick();
        rstn = 1'b1;
    endtask

    logic [TW-1:0] a [4];
    logic [TW-1:0] b [4];
    logic [TW-1:0] q [6];
    logic [TW-1:0] pa, pp;

    initial begin
        for (int i = 0; i < 4; i++) begin
            a[i] = mk(8'hA0 + 8'(i), 1'b0, 1'b1);
            b[i] = mk(8'hB0 + 8'(i), 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) q[i] = mk(8'hC0 + 8'(i), 1'b1, 1'b1);
        pa = mk(8'h5A, 1'b1, 1'b0);
        pp = mk(8'h77, 1'b0, 1'b0);

        // Reset values
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_valid", 32'(o_valid_pe), 32'd0);
        chk("rst_data", 32'(o_data_pe), 32'd0);
        chk("rst_grant", 32'(o_grant_src), 32'd0);
        chk("rst_pkt", 32'(o_pkt_cnt), 32'd0);
        chk("rst_stall", 32'(o_stall_cnt), 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("rel_s_ready", 32'(s_ready), 32'd3);

        // 1: single packet latency
        i_ready_pe = 1'b1;
        s_valid = 2'b01;
        s_data = {{TW{1'b0}}, pa};
        tick();
        s_valid = '0;
        chk("t1_not_yet", 32'(o_valid_pe), 32'd0);
        tick();
        chk("t1_valid", 32'(o_valid_pe), 32'd1);
        chk("t1_data", 32'(o_data_pe), 32'(pa));
        chk("t1_grant", 32'(o_grant_src), 32'd0);
        tick();
        chk("t1_pkt", 32'(o_pkt_cnt), 32'd1);
        chk("t1_idle", 32'(o_valid_pe), 32'd0);

        // 2: round-robin interleave of two full sources
        do_reset();
        i_ready_pe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 2'b11;
            s_data = {b[i], a[i]};
            tick();
        end
        s_valid = '0;
        chk("t2_head", 32'(o_data_pe), 32'(a[0]));
        chk("t2_stall", 32'(o_stall_cnt), 32'd2);
        i_ready_pe = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t2_order", 32'(o_data_pe), (i % 2 == 0) ? 32'(b[i/2]) : 32'(a[i/2 + 1]));
            chk("t2_src", 32'(o_grant_src), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        tick();
        chk("t2_drained", 32'(o_valid_pe), 32'd0);
        chk("t2_pkt", 32'(o_pkt_cnt), 32'd8);

        // 3: hold stable under back-pressure
        clr_stats = 1'b1;
        i_ready_pe = 1'b0;
        s_valid = 2'b01;
        s_data = {{TW{1'b0}}, pp};
        tick();
        clr_stats = 1'b0;
        s_valid = '0;
        chk("t3_clr_pkt", 32'(o_pkt_cnt), 32'd0);
        tick();
        chk("t3_valid", 32'(o_valid_pe), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stable", 32'(o_data_pe), 32'(pp));
        end
        chk("t3_stall", 32'(o_stall_cnt), 32'd5);
        i_ready_pe = 1'b1;
        tick();
        chk("t3_accept_once", 32'(o_valid_pe), 32'd0);
        chk("t3_pkt", 32'(o_pkt_cnt), 32'd1);
        chk("t3_stall_hold", 32'(o_stall_cnt), 32'd5);

        // 4: full FIFO on source 1
        i_ready_pe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("t4_ready_before", 32'(s_ready[1]), 32'd1);
            s_valid = 2'b10;
            s_data = {q[i], {TW{1'b0}}};
            tick();
        end
        chk("t4_full", 32'(s_ready[1]), 32'd0);
        s_data = {q[5], {TW{1'b0}}};
        tick();
        s_valid = '0;
        chk("t4_still_full", 32'(s_ready[1]), 32'd0);
        chk("t4_held", 32'(o_data_pe), 32'(q[0]));
        i_ready_pe = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("t4_drain", 32'(o_data_pe), 32'(q[i]));
            if (i == 1) chk("t4_ready_back", 32'(s_ready[1]), 32'd1);
        end
        tick();
        chk("t4_no_extra", 32'(o_valid_pe), 32'd0);

        // 5: reset mid-burst
        i_ready_pe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 2'b11;
            s_data = {b[i], a[i]};
            tick();
        end
        s_valid = '0;
        chk("t5_pre_valid", 32'(o_valid_pe), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(o_valid_pe), 32'd0);
        chk("t5_rst_ready", 32'(s_ready), 32'd0);
        tick();
        rstn = 1'b1;
        #1;
        chk("t5_rel_ready", 32'(s_ready), 32'd3);
        i_ready_pe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 32'(o_valid_pe), 32'd0);
        end

        // 6: clear coinciding with an accept
        i_ready_pe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 2'b01;
            s_data = {{TW{1'b0}}, a[i]};
            tick();
        end
        s_valid = '0;
        tick();
        i_ready_pe = 1'b1;
        tick();
        chk("t6_pkt_pre", 32'(o_pkt_cnt), 32'd1);
        chk("t6_stall_pre", 32'(o_stall_cnt), 32'd1);
        chk("t6_second", 32'(o_data_pe), 32'(a[1]));
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("t6_valid", 32'(o_valid_pe), 32'd0);
        chk("t6_pkt_clr", 32'(o_pkt_cnt), 32'd0);
        chk("t6_stall_clr", 32'(o_stall_cnt), 32'd0);
        tick();
        chk("t6_pkt_stay", 32'(o_pkt_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
